// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI4 slave RAM: burst types, response codes and
// the controller state enumeration.
package axi_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_e;

endpackage

// File: rtl/axi_slave_ram_mem.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port (one cycle of latency; output holds when not reading).
module axi_slave_ram_mem #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic [DATA_W/8-1:0]      we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave memory serving one burst at a time. Writes and reads share a
// single-port RAM; simultaneous AW/AR requests are arbitrated round-robin.
module axi_slave_ram
  import axi_slave_pkg::*;
#(
  parameter int P_AXI_DATA_WIDTH = 128,
  parameter int P_AXI_ADDR_WIDTH = 32,
  parameter int P_MEM_DEPTH      = 1024
) (
  input  logic                          s_aclk,
  input  logic                          s_aresetn,
  input  logic [3:0]                    s_axi_awid,
  input  logic [P_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [3:0]                    s_axi_arid,
  input  logic [P_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [P_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [P_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [3:0]                    s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [3:0]                    s_axi_rid,
  output logic [P_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int         STRB_W    = P_AXI_DATA_WIDTH / 8;
  localparam int         OFF_W     = $clog2(STRB_W);
  localparam int         IDX_W     = $clog2(P_MEM_DEPTH);
  localparam logic [2:0] FULL_SIZE = 3'(OFF_W);

  state_e                      state, state_nxt;
  logic                        init_done, rr_write;
  logic                        awready_q, arready_q, rvalid_q, rlast_q;
  logic                        err_q, fixed_q;
  logic [3:0]                  id_q;
  logic [7:0]                  len_q;
  logic [8:0]                  cnt_q;
  logic [IDX_W-1:0]            idx_q;
  logic [1:0]                  bresp_q;
  logic                        aw_grant, ar_grant, aw_err, ar_err;
  logic                        w_fire, w_final, w_last_bad, r_fetch, r_fire;
  logic                        mem_re;
  logic [STRB_W-1:0]           mem_we;
  logic [P_AXI_DATA_WIDTH-1:0] mem_rdata;
  logic                        unused_addr;

  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  // A read fetch is held off while arready is still up so the first beat
  // appears two cycles after the AR handshake; later fetches refill the
  // output slot whenever it is empty or being consumed.
  always_comb begin
    aw_grant   = (state == IDLE) && init_done && s_axi_awvalid && (rr_write || !s_axi_arvalid);
    ar_grant   = (state == IDLE) && init_done && s_axi_arvalid && !aw_grant;
    aw_err     = (s_axi_awsize != FULL_SIZE) || (s_axi_awburst == BURST_RSVD);
    ar_err     = (s_axi_arsize != FULL_SIZE) || (s_axi_arburst == BURST_RSVD);
    w_fire     = (state == WDATA) && s_axi_wvalid;
    w_final    = w_fire && (cnt_q == {1'b0, len_q});
    w_last_bad = w_fire && (s_axi_wlast != (cnt_q == {1'b0, len_q}));
    r_fetch    = (state == RDATA) && !arready_q && (cnt_q <= {1'b0, len_q})
                 && (!rvalid_q || s_axi_rready);
    r_fire     = rvalid_q && s_axi_rready;
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (aw_grant)      state_nxt = WDATA;
        else if (ar_grant) state_nxt = RDATA;
      end
      WDATA:   if (w_final) state_nxt = WRESP;
      WRESP:   if (s_axi_bready) state_nxt = IDLE;
      RDATA:   if (r_fire && rlast_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching and arbitration; the pointer flips on every grant so
  // back-to-back contention alternates write, read, write, read.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      init_done <= 1'b0;
      rr_write  <= 1'b1;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      id_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      init_done <= 1'b1;
      awready_q <= aw_grant;
      arready_q <= ar_grant;
      if (aw_grant) begin
        rr_write <= 1'b0;
        id_q     <= s_axi_awid;
        len_q    <= s_axi_awlen;
        idx_q    <= s_axi_awaddr[OFF_W +: IDX_W];
        fixed_q  <= (s_axi_awburst == BURST_FIXED);
        err_q    <= aw_err;
        bresp_q  <= aw_err ? RESP_SLVERR : RESP_OKAY;
        cnt_q    <= '0;
      end else if (ar_grant) begin
        rr_write <= 1'b1;
        id_q     <= s_axi_arid;
        len_q    <= s_axi_arlen;
        idx_q    <= s_axi_araddr[OFF_W +: IDX_W];
        fixed_q  <= (s_axi_arburst == BURST_FIXED);
        err_q    <= ar_err;
        cnt_q    <= '0;
      end else if (w_fire || r_fetch) begin
        cnt_q <= cnt_q + 9'd1;
        if (!fixed_q) idx_q <= idx_q + IDX_W'(1);
      end
      if (w_last_bad) bresp_q <= RESP_SLVERR;
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else if (r_fetch) begin
      rvalid_q <= 1'b1;
      rlast_q  <= (cnt_q == {1'b0, len_q});
    end else if (r_fire) begin
      rvalid_q <= 1'b0;
    end
  end

  assign mem_we = (w_fire && !err_q) ? s_axi_wstrb : '0;
  assign mem_re = r_fetch && !err_q;

  axi_slave_ram_mem #(
    .DATA_W (P_AXI_DATA_WIDTH),
    .DEPTH  (P_MEM_DEPTH)
  ) u_mem (
    .clk   (s_aclk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (idx_q),
    .wdata (s_axi_wdata),
    .rdata (mem_rdata)
  );

  assign s_axi_awready = awready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_wready  = (state == WDATA);
  assign s_axi_bvalid  = (state == WRESP);
  assign s_axi_bid     = s_axi_bvalid ? id_q : '0;
  assign s_axi_bresp   = s_axi_bvalid ? bresp_q : RESP_OKAY;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rvalid_q && rlast_q;
  assign s_axi_rid     = rvalid_q ? id_q : '0;
  assign s_axi_rresp   = (rvalid_q && err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rdata   = (rvalid_q && !err_q) ? mem_rdata : '0;

endmodule
